// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the round-robin subtractor arbiter.
// Optional feature macro: SUB_SATURATE_EN (clamps overflowed results).
package sub_arb_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t SAT_MAX = 8'sd127;
  localparam data_t SAT_MIN = -8'sd128;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/sub_8bit_signed.sv
// Existing 8-bit signed subtractor datapath: diff = a - b with signed overflow.
module sub_8bit_signed
  import sub_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] diff_o,
  output logic              ovf_o
);

  // Two's-complement difference; overflow when operand signs differ and the
  // result sign does not match the minuend.
  always_comb begin
    diff_o = a_i - b_i;
    ovf_o  = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff_o[DATA_W-1] != a_i[DATA_W-1]);
  end

endmodule

// File: rtl/sub_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr_i (wrapping)
// wins. idx_o/found_o report the winner regardless of valid_i; grant_o is
// the one-hot grant gated by valid_i.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           valid_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  // Scan N positions from the pointer, wrapping modulo N.
  always_comb begin : scan
    int unsigned   p;
    logic [IDW-1:0] pi;
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    p       = 0;
    pi      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      p = 32'(ptr_i) + k;
      if (p >= N) p = p - N;
      pi = IDW'(p);
      if (!found_o && req_i[pi]) begin
        found_o = 1'b1;
        idx_o   = pi;
      end
    end
    if (found_o && valid_i) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter sharing one sub_8bit_signed between NUM_REQ requesters,
// with a single registered output stage under valid/ready backpressure.
// Optional feature macro: SUB_SATURATE_EN (clamp to 127/-128 on overflow).
module sub_rr_arbiter
  import sub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_overflow,
  output logic [CNT_W-1:0]           op_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  data_t             rsp_result_q, rsp_result_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              free;
  logic              pick_en;
  logic              accept;
  logic              found;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   win_idx;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [DATA_W-1:0] diff;
  logic              ovf;
  data_t             res_final;

  // Output slot can take a new result when empty or being drained this cycle.
  always_comb begin
    free    = (state_q == EMPTY) || rsp_ready;
    pick_en = free && !rst;
    accept  = found && pick_en;
  end

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .valid_i (pick_en),
    .grant_o (grant),
    .idx_o   (win_idx),
    .found_o (found)
  );

  assign req_ready = grant;

  // NUM_REQ:1 operand mux steered by the winner index.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        a_sel = req_a[DATA_W*i +: DATA_W];
        b_sel = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  sub_8bit_signed u_sub (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .diff_o (diff),
    .ovf_o  (ovf)
  );

  // Result seen by the output register: wrapped or saturated difference.
  always_comb begin
`ifdef SUB_SATURATE_EN
    if (ovf) res_final = a_sel[DATA_W-1] ? SAT_MIN : SAT_MAX;
    else     res_final = data_t'(diff);
`else
    res_final = data_t'(diff);
`endif
  end

  // Next-state logic for output-register occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Datapath next values: load on accept, otherwise hold.
  always_comb begin
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rr_ptr_d       = rr_ptr_q;
    op_count_d     = op_count_q;
    if (accept) begin
      rsp_id_d       = win_idx;
      rsp_result_d   = res_final;
      rsp_overflow_d = ovf;
      rr_ptr_d       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      op_count_d     = op_count_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Result register, round-robin pointer and operation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rr_ptr_q       <= '0;
      op_count_q     <= '0;
    end else begin
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rr_ptr_q       <= rr_ptr_d;
      op_count_q     <= op_count_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Self-checking bench for sub_rr_arbiter (NUM_REQ=4, CNT_W=4).
module tb_sub_rr_arbiter;

  localparam int NR = 4;
  localparam int CW = 4;

`ifdef SUB_SATURATE_EN
  localparam logic [7:0] C_POS = 8'h7f;
  localparam logic [7:0] C_NEG = 8'h80;
`else
  localparam logic [7:0] C_POS = 8'h80;
  localparam logic [7:0] C_NEG = 8'h7f;
`endif

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [7:0]    rsp_result;
  logic          rsp_overflow;
  logic [CW-1:0] op_count;

  sub_rr_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int         n_vec = 0;
  int         n_mis = 0;
  int         m_full = 0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [1:0] h_id = '0;
  logic [7:0] h_res = '0;
  logic       h_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t calc(input int id, input logic [7:0] a, input logic [7:0] b);
    int          d;
    logic [31:0] dv;
    exp_t        e;
    d     = int'($signed(a)) - int'($signed(b));
    dv    = d;
    e.id  = 2'(id);
    e.ovf = (d > 127) || (d < -128);
    e.res = dv[7:0];
`ifdef SUB_SATURATE_EN
    if (e.ovf) e.res = (d > 127) ? 8'h7f : 8'h80;
`endif
    return e;
  endfunction

  function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  // One clock cycle: drive at negedge, check registered outputs and the
  // predicted grant, then advance the reference model.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic rr);
    int         win;
    logic [3:0] exp_rdy;
    exp_t       e;
    @(negedge clk);
    rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full != 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
      chk("rsp_overflow", 32'(rsp_overflow), 32'(sb[0].ovf));
    end else begin
      chk("hold_id", 32'(rsp_id), 32'(h_id));
      chk("hold_result", 32'(rsp_result), 32'(h_res));
      chk("hold_overflow", 32'(rsp_overflow), 32'(h_ovf));
    end
    chk("op_count", 32'(op_count), 32'(m_cnt % 16));
    win = -1;
    exp_rdy = '0;
    if (!r && (m_full == 0 || rr)) begin
      for (int k = 0; k < NR; k++) begin
        if (win < 0 && v[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (r) begin
      sb.delete();
      m_full = 0; m_ptr = 0; m_cnt = 0;
      h_id = '0; h_res = '0; h_ovf = 1'b0;
    end else begin
      if (m_full != 0 && rr) begin
        e = sb.pop_front();
        h_id = e.id; h_res = e.res; h_ovf = e.ovf;
        m_full = 0;
      end
      if (win >= 0) begin
        sb.push_back(calc(win, a[8*win +: 8], b[8*win +: 8]));
        m_full = 1;
        m_ptr  = (win + 1) % NR;
        m_cnt++;
      end
    end
  endtask

  // Spot-check the result register right after an edge against fixed values.
  task automatic peek(input string tag, input logic [7:0] r, input logic o, input logic [1:0] id);
    @(posedge clk);
    #1;
    chk({tag, "_res"}, 32'(rsp_result), 32'(r));
    chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(o));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa, fb, ra, rb;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    cycle(1, 4'b0000, '0, '0, 1);
    cycle(1, 4'b1111, '0, '0, 1);

    // Single request
    cycle(0, 4'b0001, pack4(5, 0, 0, 0), pack4(3, 0, 0, 0), 1);
    peek("single", 8'd2, 1'b0, 2'd0);
    chk("single_cnt", 32'(op_count), 32'd1);

    // Overflow corners
    cycle(0, 4'b0010, pack4(0, 127, 0, 0), pack4(0, -1, 0, 0), 1);
    peek("ovf_pos", C_POS, 1'b1, 2'd1);
    cycle(0, 4'b0100, pack4(0, 0, -128, 0), pack4(0, 0, 1, 0), 1);
    peek("ovf_neg", C_NEG, 1'b1, 2'd2);
    cycle(0, 4'b1000, pack4(0, 0, 0, -1), pack4(0, 0, 0, -128), 1);
    peek("no_ovf", 8'h7f, 1'b0, 2'd3);
    cycle(0, 4'b0000, '0, '0, 1);

    // Fairness: all valid, no backpressure
    fa = pack4(10, 20, -30, -100);
    fb = pack4(1, -5, 100, 40);
    for (int i = 0; i < 6; i++) cycle(0, 4'b1111, fa, fb, 1);

    // Backpressure while FULL
    for (int i = 0; i < 3; i++) cycle(0, 4'b1111, fa, fb, 0);
    cycle(0, 4'b1111, fa, fb, 1);
    cycle(0, 4'b0000, fa, fb, 1);
    cycle(0, 4'b0000, fa, fb, 1);

    // Reset while FULL, then first grant goes to requester 0
    cycle(0, 4'b1111, fa, fb, 1);
    cycle(0, 4'b1111, fa, fb, 0);
    cycle(1, 4'b1111, fa, fb, 1);
    cycle(0, 4'b1111, fa, fb, 1);
    cycle(0, 4'b0000, fa, fb, 1);

    // Random valid/ready with per-requester fixed operands
    ra = $urandom();
    rb = $urandom();
    for (int i = 0; i < 24; i++) cycle(0, 4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)));
    cycle(0, 4'b0000, ra, rb, 1);

    // Counter wrap: 17 accepts after reset on a 4-bit counter
    cycle(1, 4'b0000, '0, '0, 1);
    for (int i = 0; i < 17; i++) cycle(0, 4'b1111, fa, fb, 1);
    cycle(0, 4'b0000, fa, fb, 1);
    chk("cnt_wrap", 32'(op_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
